// File: rtl/imu_seq_pkg.sv
// Shared types and command constants for the IMU read sequencer.
package imu_seq_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG_WR,
    CFG_WAIT,
    IDLE,
    RD_WR,
    RD_WAIT,
    UPDATE
  } state_t;

  // Sensor configuration writes, issued once after power-up in this order
  localparam logic [15:0] CFG_CMD0 = 16'h0D02;
  localparam logic [15:0] CFG_CMD1 = 16'h1053;
  localparam logic [15:0] CFG_CMD2 = 16'h1150;
  localparam logic [15:0] CFG_CMD3 = 16'h1460;

  // Register reads: pitch rate low/high, Z acceleration low/high
  localparam logic [15:0] RD_CMD0 = 16'hA200;
  localparam logic [15:0] RD_CMD1 = 16'hA300;
  localparam logic [15:0] RD_CMD2 = 16'hAC00;
  localparam logic [15:0] RD_CMD3 = 16'hAD00;

  function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CFG_CMD0;
      2'd1:    return CFG_CMD1;
      2'd2:    return CFG_CMD2;
      default: return CFG_CMD3;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return RD_CMD0;
      2'd1:    return RD_CMD1;
      2'd2:    return RD_CMD2;
      default: return RD_CMD3;
    endcase
  endfunction

endpackage

// File: rtl/imu_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the input; only q is safe to use in the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/imu_seq.sv
// IMU sequencer: power-up wait, sensor configuration, then a four-byte
// SPI read of pitch rate and Z acceleration on every data-ready interrupt.
module imu_seq
  import imu_seq_pkg::*;
#(
  parameter int INIT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  input  logic               done,
  input  logic        [15:0] rd_data,
  output logic               wrt,
  output logic        [15:0] cmd,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] AZ,
  output logic               vld
);

  state_t            state;
  logic [INIT_W-1:0] pwr_cnt;
  logic [1:0]        idx;
  logic [7:0]        byte0;
  logic [7:0]        byte1;
  logic [7:0]        byte2;
  logic              int_s;

  // Only the low byte of each SPI response carries register data
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  sync2 u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  // Sequencer FSM; wrt/cmd/vld are registered so they are asserted exactly
  // while the FSM sits in CFG_WR/RD_WR (wrt) or UPDATE (vld). The last byte
  // is taken straight from rd_data on the edge that enters UPDATE, so only
  // three holding bytes are needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PWR_WAIT;
      pwr_cnt <= '0;
      idx     <= '0;
      byte0   <= '0;
      byte1   <= '0;
      byte2   <= '0;
      wrt     <= 1'b0;
      cmd     <= '0;
      ptch_rt <= '0;
      AZ      <= '0;
      vld     <= 1'b0;
    end else begin
      wrt <= 1'b0;
      cmd <= '0;
      vld <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (pwr_cnt == '1) begin
            state <= CFG_WR;
            idx   <= '0;
            wrt   <= 1'b1;
            cmd   <= cfg_cmd(2'd0);
          end else begin
            pwr_cnt <= pwr_cnt + INIT_W'(1);
          end
        end
        CFG_WR: state <= CFG_WAIT;
        CFG_WAIT: begin
          if (done) begin
            if (idx == 2'd3) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              state <= CFG_WR;
              idx   <= idx + 2'd1;
              wrt   <= 1'b1;
              cmd   <= cfg_cmd(idx + 2'd1);
            end
          end
        end
        IDLE: begin
          if (int_s) begin
            state <= RD_WR;
            idx   <= '0;
            wrt   <= 1'b1;
            cmd   <= rd_cmd(2'd0);
          end
        end
        RD_WR: state <= RD_WAIT;
        RD_WAIT: begin
          if (done) begin
            case (idx)
              2'd0:    byte0 <= rd_data[7:0];
              2'd1:    byte1 <= rd_data[7:0];
              2'd2:    byte2 <= rd_data[7:0];
              default: ;
            endcase
            if (idx == 2'd3) begin
              state   <= UPDATE;
              idx     <= '0;
              vld     <= 1'b1;
              ptch_rt <= $signed({byte1, byte0});
              AZ      <= $signed({rd_data[7:0], byte2});
            end else begin
              state <= RD_WR;
              idx   <= idx + 2'd1;
              wrt   <= 1'b1;
              cmd   <= rd_cmd(idx + 2'd1);
            end
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule
